lut_cfg_loader: RTL and testbench

LUT_CFG_LOADER -- requirements
Module: lut_cfg_loader

---
 rtl/lut_cfg_loader.sv | 115 +++++++++++
 tb/tb_lut_cfg_loader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/lut_cfg_loader.sv
// lut_cfg_loader: deserialises framed bitstreams into LUT config words and pulses one target's enable per good frame
//   cclk       configuration clock, all state on posedge
//   rst        asynchronous active-high reset
//   bs_valid   bitstream beat valid
//   bs_data    bitstream bit
//   bs_sof     start-of-frame, qualifies the first beat of a frame
//   bs_ready   loader accepts a beat this cycle (low only in COMMIT)
//   err_clr    clears the sticky error
//   config_out config word broadcast to all targets
//   cen_out    one-hot per-target config enable, high for the single COMMIT cycle
//   busy       high whenever a frame is in progress or committing
//   err        sticky frame error (bad parity, bad address, or aborted frame)
//   frames_ok  saturating count of committed frames
module lut_cfg_loader #(
    parameter int INPUTS      = 4,
    parameter int MEM_SIZE    = 2**INPUTS,
    parameter int CFG_WIDTH   = 2*MEM_SIZE+1,
    parameter int NUM_TARGETS = 4
) (
    input  logic                   cclk,
    input  logic                   rst,
    input  logic                   bs_valid,
    input  logic                   bs_data,
    input  logic                   bs_sof,
    output logic                   bs_ready,
    input  logic                   err_clr,
    output logic [CFG_WIDTH-1:0]   config_out,
    output logic [NUM_TARGETS-1:0] cen_out,
    output logic                   busy,
    output logic                   err,
    output logic [7:0]             frames_ok
);
    localparam int ADDR_W = $clog2(NUM_TARGETS);
    localparam int CNT_W  = $clog2(CFG_WIDTH + ADDR_W + 1);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, PARITY, COMMIT} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_sr;
    logic [CFG_WIDTH-1:0] data_sr;
    logic [CNT_W-1:0]    cnt;
    logic                par;
    logic                beat, start, last_addr, last_data, frame_ok, err_set;

    assign bs_ready  = state != COMMIT;
    assign busy      = state != IDLE;
    assign beat      = bs_valid & bs_ready;
    // any accepted sof beat starts a fresh frame, even mid-frame
    assign start     = beat & bs_sof;
    assign last_addr = cnt == CNT_W'(ADDR_W - 1);
    assign last_data = cnt == CNT_W'(CFG_WIDTH - 1);
    // par holds the XOR of address and payload bits; the parity beat must cancel it
    assign frame_ok  = !(par ^ bs_data) && ({1'b0, addr_sr} < (ADDR_W+1)'(NUM_TARGETS));
    assign err_set   = (start && state != IDLE) || (beat && !bs_sof && state == PARITY && !frame_ok);
    assign cen_out   = state == COMMIT ? NUM_TARGETS'(1) << addr_sr : '0;

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start) state_nxt = ADDR_W == 1 ? DATA : ADDR;
        else begin
            case (state)
                ADDR:    if (beat && last_addr) state_nxt = DATA;
                DATA:    if (beat && last_data) state_nxt = PARITY;
                PARITY:  if (beat) state_nxt = frame_ok ? COMMIT : IDLE;
                COMMIT:  state_nxt = IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            addr_sr    <= '0;
            data_sr    <= '0;
            cnt        <= '0;
            par        <= 1'b0;
            config_out <= '0;
            frames_ok  <= '0;
            err        <= 1'b0;
        end else begin
            // a new error wins over a simultaneous clear
            err <= err_set | (err & ~err_clr);
            if (start) begin
                addr_sr <= ADDR_W'(bs_data);
                cnt     <= ADDR_W == 1 ? '0 : CNT_W'(1);
                par     <= bs_data;
            end else if (beat) begin
                case (state)
                    ADDR: begin
                        addr_sr <= (addr_sr << 1) | ADDR_W'(bs_data);
                        cnt     <= last_addr ? '0 : cnt + CNT_W'(1);
                        par     <= par ^ bs_data;
                    end
                    DATA: begin
                        data_sr <= (data_sr << 1) | CFG_WIDTH'(bs_data);
                        cnt     <= last_data ? '0 : cnt + CNT_W'(1);
                        par     <= par ^ bs_data;
                    end
                    PARITY: begin
                        if (frame_ok) begin
                            config_out <= data_sr;
                            frames_ok  <= frames_ok != 8'hFF ? frames_ok + 8'd1 : frames_ok;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lut_cfg_loader.sv
// tb_lut_cfg_loader: scoreboard bench for lut_cfg_loader with default parameters (4 targets, 33-bit config)
module tb_lut_cfg_loader;
    localparam int CW = 33;
    localparam int NT = 4;
    localparam int AW = 2;

    logic          cclk = 0;
    logic          rst = 0;
    logic          bs_valid = 0;
    logic          bs_data = 0;
    logic          bs_sof = 0;
    logic          err_clr = 0;
    logic          bs_ready;
    logic [CW-1:0] config_out;
    logic [NT-1:0] cen_out;
    logic          busy;
    logic          err;
    logic [7:0]    frames_ok;

    lut_cfg_loader dut (
        .cclk(cclk), .rst(rst), .bs_valid(bs_valid), .bs_data(bs_data), .bs_sof(bs_sof),
        .bs_ready(bs_ready), .err_clr(err_clr), .config_out(config_out), .cen_out(cen_out),
        .busy(busy), .err(err), .frames_ok(frames_ok)
    );

    always #5 cclk = ~cclk;

    typedef struct {
        logic [NT-1:0] cen;
        logic [CW-1:0] cfg;
    } exp_t;

    exp_t          sb[$];
    logic [CW-1:0] exp_cfg = '0;
    int            exp_frames = 0;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge cclk) begin
        exp_t e;
        if (rst) begin
            exp_cfg = '0;
            exp_frames = 0;
            chk("rst_cen", cen_out, 0);
            chk("rst_cfg", config_out, 0);
            chk("rst_frames", frames_ok, 0);
            chk("rst_busy", busy, 0);
            chk("rst_err", err, 0);
            chk("rst_ready", bs_ready, 1);
        end else begin
            if (cen_out != 0) begin
                chk("cen_onehot", $onehot(cen_out), 1);
                if (sb.size() == 0) chk("cen_unexpected", cen_out, 0);
                else begin
                    e = sb.pop_front();
                    chk("cen", cen_out, e.cen);
                    exp_cfg = e.cfg;
                    exp_frames = exp_frames == 255 ? 255 : exp_frames + 1;
                end
            end
            chk("cfg", config_out, exp_cfg);
            chk("frames", frames_ok, exp_frames);
            chk("ready", bs_ready, cen_out == 0);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge cclk);
            #1;
        end
    endtask

    task automatic send_bit(input logic d, input logic sof, input bit gaps);
        int   tries = 0;
        logic r;
        while (gaps && $urandom_range(1) == 1) begin
            bs_valid = 0;
            @(posedge cclk);
            #1;
        end
        bs_valid = 1;
        bs_data  = d;
        bs_sof   = sof;
        do begin
            r = bs_ready;
            @(posedge cclk);
            #1;
            tries++;
        end while (!r && tries < 8);
        if (!r) chk("beat_timeout", 0, 1);
        bs_valid = 0;
        bs_sof   = 0;
    endtask

    task automatic send_frame(input logic [AW-1:0] addr, input logic [CW-1:0] cfg,
                              input bit bad, input bit gaps, input int stop);
        logic bits[$];
        logic p = 0;
        exp_t e;
        for (int i = AW-1; i >= 0; i--) bits.push_back(addr[i]);
        for (int i = CW-1; i >= 0; i--) bits.push_back(cfg[i]);
        foreach (bits[i]) p ^= bits[i];
        bits.push_back(p ^ bad);
        if (!bad && stop >= bits.size()) begin
            e.cen = NT'(1) << addr;
            e.cfg = cfg;
            sb.push_back(e);
        end
        for (int i = 0; i < stop && i < bits.size(); i++) send_bit(bits[i], i == 0, gaps);
    endtask

    initial begin
        #1 rst = 1;
        wait_cyc(3);
        rst = 0;
        wait_cyc(1);
        chk("idle_busy", busy, 0);
        chk("idle_ready", bs_ready, 1);

        for (int i = 0; i < 3; i++) send_bit(1, 0, 0);
        chk("discard_busy", busy, 0);
        chk("discard_err", err, 0);

        send_frame(2, 33'h1_0000_ABCD, 0, 0, 36);
        wait_cyc(2);
        chk("good_frames", frames_ok, 1);
        chk("good_err", err, 0);
        chk("good_cfg", config_out, 33'h1_0000_ABCD);

        send_frame(2, 33'h1_0000_ABCD, 1, 0, 36);
        wait_cyc(2);
        chk("badpar_err", err, 1);
        chk("badpar_frames", frames_ok, 1);
        chk("badpar_busy", busy, 0);
        err_clr = 1;
        wait_cyc(1);
        err_clr = 0;
        chk("errclr", err, 0);

        send_frame(1, 33'h0_1234_5678, 0, 0, AW + 10);
        send_frame(0, 33'h1_8765_4321, 0, 0, 36);
        wait_cyc(2);
        chk("abort_err", err, 1);
        chk("abort_frames", frames_ok, 2);
        chk("abort_cfg", config_out, 33'h1_8765_4321);
        err_clr = 1;
        wait_cyc(1);
        chk("errclr2", err, 0);

        send_frame(3, 33'h0_0F0F_0F0F, 1, 0, 36);
        err_clr = 0;
        chk("err_beats_clr", err, 1);
        err_clr = 1;
        wait_cyc(1);
        err_clr = 0;

        send_frame(3, 33'h0_DEAD_BEEF, 0, 1, 36);
        wait_cyc(2);
        chk("gap_frames", frames_ok, 3);
        chk("gap_err", err, 0);
        chk("gap_cfg", config_out, 33'h0_DEAD_BEEF);

        send_frame(1, 33'h1_FFFF_0000, 0, 0, AW + 20);
        rst = 1;
        wait_cyc(2);
        rst = 0;
        wait_cyc(1);
        chk("postrst_busy", busy, 0);
        chk("postrst_frames", frames_ok, 0);
        send_frame(1, 33'h1_5555_AAAA, 0, 0, 36);
        wait_cyc(2);
        chk("postrst_good", frames_ok, 1);

        for (int i = 0; i < 260; i++)
            send_frame(AW'($urandom_range(0, 3)), {1'($urandom_range(1)), 32'($urandom)}, 0, 0, 36);
        wait_cyc(3);
        chk("saturate", frames_ok, 255);
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
